// File: rtl/unidade_controle.sv
// Control unit for a small register-file/ALU datapath: accepts one 16-bit
// instruction at a time and sequences operand loads, ALU execute or immediate write.
module unidade_controle (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        carry_out,
  output logic        escrita,
  output logic [1:0]  reg_addr,
  output logic        sel12,
  output logic        sel21,
  output logic [2:0]  operacao,
  output logic        carry_in,
  output logic [3:0]  dados,
  output logic        busy,
  output logic        done,
  output logic        flag_carry,
  output logic [7:0]  instr_count
);

  // Handshake: an instruction transfers on a rising edge where
  // instr_valid & instr_ready; instr_ready is high only in IDLE out of reset.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    EXEC      = 3'd3,
    WRITE_IMM = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  ra_q, ra_d;
  logic [1:0]  rb_q, rb_d;
  logic        cin_q, cin_d;
  logic [3:0]  imm_q, imm_d;
  logic        done_q, done_d;
  logic        flag_carry_q, flag_carry_d;
  logic [7:0]  count_q, count_d;
  logic        accept;
  logic        unused_reserved;

  assign unused_reserved = instr[4];
  assign instr_ready     = (state_q == IDLE) && !reset;
  assign accept          = instr_valid && instr_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    cin_d        = cin_q;
    imm_d        = imm_q;
    done_d       = 1'b0;
    flag_carry_d = flag_carry_q;
    count_d      = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = instr[14:12];
          rd_d    = instr[11:10];
          ra_d    = instr[9:8];
          rb_d    = instr[7:6];
          cin_d   = instr[5];
          imm_d   = instr[3:0];
          state_d = instr[15] ? WRITE_IMM : LOAD_A;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = EXEC;
      EXEC: begin
        state_d      = IDLE;
        done_d       = 1'b1;
        flag_carry_d = carry_out;
        count_d      = count_q + 8'd1;
      end
      WRITE_IMM: begin
        state_d = IDLE;
        done_d  = 1'b1;
        count_d = count_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over every transition, so an aborted write never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      cin_q        <= 1'b0;
      imm_q        <= '0;
      done_q       <= 1'b0;
      flag_carry_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      cin_q        <= cin_d;
      imm_q        <= imm_d;
      done_q       <= done_d;
      flag_carry_q <= flag_carry_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    escrita  = 1'b0;
    reg_addr = 2'b00;
    sel12    = 1'b0;
    sel21    = 1'b0;
    operacao = 3'b000;
    carry_in = 1'b0;
    busy     = 1'b0;
    case (state_q)
      LOAD_A: begin
        reg_addr = ra_q;
        operacao = op_q;
        busy     = 1'b1;
      end
      LOAD_B: begin
        reg_addr = rb_q;
        sel12    = 1'b1;
        operacao = op_q;
        busy     = 1'b1;
      end
      EXEC: begin
        reg_addr = rd_q;
        sel12    = 1'b1;
        sel21    = 1'b1;
        escrita  = !reset;
        operacao = op_q;
        carry_in = cin_q;
        busy     = 1'b1;
      end
      WRITE_IMM: begin
        reg_addr = rd_q;
        escrita  = !reset;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign dados       = imm_q;
  assign done        = done_q;
  assign flag_carry  = flag_carry_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: reset, load, ALU, carry flag, abort,
// busy-ignore, back-to-back acceptance and counter wrap.
module tb_unidade_controle;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        carry_out;
  logic        escrita;
  logic [1:0]  reg_addr;
  logic        sel12;
  logic        sel21;
  logic [2:0]  operacao;
  logic        carry_in;
  logic [3:0]  dados;
  logic        busy;
  logic        done;
  logic        flag_carry;
  logic [7:0]  instr_count;

  int          checks;
  int          errors;
  logic [7:0]  exp_count;

  // {instr_ready, busy, escrita, reg_addr, sel12, sel21, operacao, carry_in}
  logic [10:0] ctl;
  assign ctl = {instr_ready, busy, escrita, reg_addr, sel12, sel21, operacao, carry_in};

  unidade_controle dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .carry_out   (carry_out),
    .escrita     (escrita),
    .reg_addr    (reg_addr),
    .sel12       (sel12),
    .sel21       (sel21),
    .operacao    (operacao),
    .carry_in    (carry_in),
    .dados       (dados),
    .busy        (busy),
    .done        (done),
    .flag_carry  (flag_carry),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b1; instr = 16'h8805; carry_out = 1'b0;
    step(); step();
    checks++;
    if (ctl !== 11'b0_0_0_00_0_0_000_0) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl, 11'b0);
    end
    checks++;
    if ({done, flag_carry, instr_count, dados} !== 14'd0) begin
      errors++; $display("FAIL reset_regs got done=%b flag=%b cnt=%h dados=%h want 0",
                         done, flag_carry, instr_count, dados);
    end
    reset = 1'b0; instr_valid = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after got %b want 1", instr_ready);
    end
    exp_count = 8'h00;
  endtask

  task automatic test_abort();
    instr = 16'h0DA0; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if ({escrita, busy} !== 2'b01) begin
      errors++; $display("FAIL abort_escrita got esc=%b busy=%b want esc=0 busy=1", escrita, busy);
    end
    step(); reset = 1'b0;
    checks++;
    if ({busy, done, instr_count} !== 10'd0) begin
      errors++; $display("FAIL abort_idle got busy=%b done=%b cnt=%h want 0 0 00", busy, done, instr_count);
    end
    step();
    checks++;
    if ({done, instr_count, instr_ready} !== 10'b0_00000000_1) begin
      errors++; $display("FAIL abort_nodone got done=%b cnt=%h rdy=%b want 0 00 1", done, instr_count, instr_ready);
    end
  endtask

  task automatic test_load();
    instr = 16'h8805; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    checks++;
    if (ctl !== 11'b0_1_1_10_0_0_000_0 || dados !== 4'h5) begin
      errors++; $display("FAIL load_write got ctl=%b dados=%h want %b 5", ctl, dados, 11'b0_1_1_10_0_0_000_0);
    end
    step(); exp_count++;
    checks++;
    if ({done, busy, escrita, instr_count} !== {3'b100, exp_count}) begin
      errors++; $display("FAIL load_done got done=%b busy=%b esc=%b cnt=%h want 1 0 0 %h",
                         done, busy, escrita, instr_count, exp_count);
    end
  endtask

  task automatic test_alu();
    instr = 16'h0DA0; instr_valid = 1'b1; carry_out = 1'b0;
    step(); instr_valid = 1'b0;
    checks++;
    if (ctl !== 11'b0_1_0_01_0_0_000_0) begin
      errors++; $display("FAIL alu_c1 got %b want %b", ctl, 11'b0_1_0_01_0_0_000_0);
    end
    step();
    checks++;
    if (ctl !== 11'b0_1_0_10_1_0_000_0) begin
      errors++; $display("FAIL alu_c2 got %b want %b", ctl, 11'b0_1_0_10_1_0_000_0);
    end
    step();
    checks++;
    if (ctl !== 11'b0_1_1_11_1_1_000_1) begin
      errors++; $display("FAIL alu_c3 got %b want %b", ctl, 11'b0_1_1_11_1_1_000_1);
    end
    step(); exp_count++;
    checks++;
    if ({done, busy, flag_carry, instr_count} !== {3'b100, exp_count}) begin
      errors++; $display("FAIL alu_done got done=%b busy=%b flag=%b cnt=%h want 1 0 0 %h",
                         done, busy, flag_carry, instr_count, exp_count);
    end
  endtask

  // op=5 rd=1 ra=2 rb=3 cin=0; instr_valid toggles with a different word while busy.
  task automatic test_carry_busy();
    instr = 16'h56C0; instr_valid = 1'b1;
    step();
    instr = 16'h8C0A; instr_valid = 1'b0;
    checks++;
    if (ctl !== 11'b0_1_0_10_0_0_101_0) begin
      errors++; $display("FAIL carry_lda got %b want %b", ctl, 11'b0_1_0_10_0_0_101_0);
    end
    instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    checks++;
    if (ctl !== 11'b0_1_0_11_1_0_101_0 || dados !== 4'h0) begin
      errors++; $display("FAIL busy_ignore_ldb got ctl=%b dados=%h want %b 0", ctl, dados, 11'b0_1_0_11_1_0_101_0);
    end
    instr_valid = 1'b1;
    step();
    checks++;
    if (ctl !== 11'b0_1_1_01_1_1_101_0) begin
      errors++; $display("FAIL carry_exec got %b want %b", ctl, 11'b0_1_1_01_1_1_101_0);
    end
    instr_valid = 1'b0; carry_out = 1'b1;
    step(); carry_out = 1'b0; exp_count++;
    checks++;
    if ({flag_carry, done, instr_count} !== {2'b11, exp_count}) begin
      errors++; $display("FAIL carry_flag got flag=%b done=%b cnt=%h want 1 1 %h", flag_carry, done, instr_count, exp_count);
    end
    instr = 16'h8805; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step(); exp_count++;
    checks++;
    if ({flag_carry, done, instr_count} !== {2'b11, exp_count}) begin
      errors++; $display("FAIL carry_kept got flag=%b done=%b cnt=%h want 1 1 %h", flag_carry, done, instr_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] start;
    start = exp_count;
    instr = 16'h8805; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step(); exp_count++;
    instr = 16'h8C0A; instr_valid = 1'b1;
    step();
    checks++;
    if (ctl !== 11'b0_1_1_11_0_0_000_0 || dados !== 4'hA || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got ctl=%b dados=%h done=%b want %b a 0",
                         ctl, dados, done, 11'b0_1_1_11_0_0_000_0);
    end
    step(); exp_count++;
    for (int i = 0; i < 256; i++) begin
      step();
      step(); exp_count++;
      checks++;
      if ({done, instr_count} !== {1'b1, exp_count}) begin
        errors++; $display("FAIL wrap_iter%0d got done=%b cnt=%h want 1 %h", i, done, instr_count, exp_count);
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (instr_count !== start + 8'd2) begin
      errors++; $display("FAIL wrap_total got %h want %h", instr_count, start + 8'd2);
    end
    step();
    checks++;
    if ({done, busy, instr_ready} !== 3'b001) begin
      errors++; $display("FAIL final_idle got done=%b busy=%b rdy=%b want 0 0 1", done, busy, instr_ready);
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_count = 8'h00;
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; carry_out = 1'b0;
    test_reset();
    test_abort();
    test_load();
    test_alu();
    test_carry_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
